// File: rtl/flash_reader_pkg.sv
// flash_reader_pkg: shared types and helpers for the flash sample reader.
`default_nettype none

package flash_reader_pkg;

   localparam int SAMPLE_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REQ       = 3'd1,
      WAIT_DATA = 3'd2,
      HOLD      = 3'd3,
      SETTLE    = 3'd4
   } state_t;

   // Forward playback emits the low half first; backward emits the high half first.
   function automatic logic [SAMPLE_WIDTH-1:0] select_half(
      input logic [2*SAMPLE_WIDTH-1:0] word,
      input logic                      dir,
      input logic                      second
   );
      return (dir ^ second) ? word[SAMPLE_WIDTH-1:0]
                            : word[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
   endfunction

endpackage

`default_nettype wire

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetches one flash word per two sample ticks and plays out its halves.
// Revision: 1.0
`default_nettype none

module flash_sample_reader
   import flash_reader_pkg::*;
#(
   parameter int ADDR_WIDTH   = 23,
   parameter int DATA_WIDTH   = 32,
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_tick,
   input  logic                    forward,
   input  logic [ADDR_WIDTH-1:0]   address,
   output logic                    change,
   output logic                    flash_read,
   output logic [ADDR_WIDTH-1:0]   flash_address,
   input  logic                    flash_waitrequest,
   input  logic                    flash_readdatavalid,
   input  logic [DATA_WIDTH-1:0]   flash_readdata,
   output logic [SAMPLE_WIDTH-1:0] sample,
   output logic                    sample_valid,
   output logic                    overrun
);

   if (DATA_WIDTH != 2 * SAMPLE_WIDTH ||
       SAMPLE_WIDTH != flash_reader_pkg::SAMPLE_WIDTH) begin : g_width_check
      $error("flash_sample_reader: DATA_WIDTH must equal 2*SAMPLE_WIDTH (16-bit samples)");
   end

   state_t                state;
   logic                  dir_q;
   logic [DATA_WIDTH-1:0] word_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         change        <= 1'b0;
         flash_read    <= 1'b0;
         flash_address <= '0;
         sample        <= '0;
         sample_valid  <= 1'b0;
         overrun       <= 1'b0;
         dir_q         <= 1'b0;
         word_q        <= '0;
      end else begin
         sample_valid <= 1'b0;
         change       <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_tick) begin
                  flash_address <= address;
                  dir_q         <= forward;
                  flash_read    <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ: begin
               if (sample_tick) overrun <= 1'b1;
               if (!flash_waitrequest) begin
                  flash_read <= 1'b0;
                  state      <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (sample_tick) overrun <= 1'b1;
               if (flash_readdatavalid) begin
                  word_q       <= flash_readdata;
                  sample       <= select_half(flash_readdata, dir_q, 1'b0);
                  sample_valid <= 1'b1;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (sample_tick) begin
                  sample       <= select_half(word_q, dir_q, 1'b1);
                  sample_valid <= 1'b1;
                  change       <= 1'b1;
                  state        <= SETTLE;
               end
            end
            SETTLE: begin
               // The address controller steps during this cycle; a tick here would see a stale address.
               if (sample_tick) overrun <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: randomized scoreboard bench with an Avalon flash model and address controller model.
`default_nettype none

module tb_flash_sample_reader;
   import flash_reader_pkg::*;

   localparam int AW = 23;
   localparam int DW = 32;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_tick;
   logic          forward;
   logic [AW-1:0] address;
   logic          change;
   logic          flash_read;
   logic [AW-1:0] flash_address;
   logic          flash_waitrequest;
   logic          flash_readdatavalid;
   logic [DW-1:0] flash_readdata;
   logic [SW-1:0] sample;
   logic          sample_valid;
   logic          overrun;

   flash_sample_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .sample_tick         (sample_tick),
      .forward             (forward),
      .address             (address),
      .change              (change),
      .flash_read          (flash_read),
      .flash_address       (flash_address),
      .flash_waitrequest   (flash_waitrequest),
      .flash_readdatavalid (flash_readdatavalid),
      .flash_readdata      (flash_readdata),
      .sample              (sample),
      .sample_valid        (sample_valid),
      .overrun             (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: forward plays low half then high half; backward the reverse.
   function automatic logic [SW-1:0] ref_half(input logic [DW-1:0] w, input logic fwd, input bit second);
      logic [SW-1:0] lo, hi;
      lo = w[15:0];
      hi = w[31:16];
      if (fwd) return second ? hi : lo;
      else     return second ? lo : hi;
   endfunction

   logic [DW-1:0] mem [16];
   logic [AW-1:0] exp_addr_q [$];
   logic [SW:0]   exp_samp_q [$];
   int ws_cfg = 0, lat_cfg = 3;
   int rd_cycles = 0, rd_acc = 0, samp_seen = 0, chg_cnt = 0, rdv_cnt = 0;
   bit ctrl_mode = 0;
   bit exp_overrun = 0;
   int last_rd_cycles, last_rd_acc;

   // Avalon flash model: programmable wait states and read latency, responses in order.
   initial begin
      int cyc = 0;
      int ws_left = 0;
      bit in_req = 0;
      logic prev_read = 0, prev_wait = 0;
      logic [AW-1:0] prev_addr = '0;
      int due_q [$];
      logic [DW-1:0] data_q [$];
      flash_waitrequest   = 1'b0;
      flash_readdatavalid = 1'b0;
      flash_readdata      = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (prev_read && !prev_wait) begin
            due_q.push_back(cyc - 1 + lat_cfg);
            data_q.push_back(mem[prev_addr[3:0]]);
         end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            flash_readdata      = data_q.pop_front();
            flash_readdatavalid = 1'b1;
            rdv_cnt++;
         end else begin
            flash_readdatavalid = 1'b0;
            flash_readdata      = $urandom;
         end
         if (flash_read) begin
            if (!in_req) begin
               in_req  = 1;
               ws_left = ws_cfg;
            end
            if (ws_left > 0) begin
               flash_waitrequest = 1'b1;
               ws_left--;
            end else begin
               flash_waitrequest = 1'b0;
            end
         end else begin
            in_req = 0;
            flash_waitrequest = 1'b0;
         end
         prev_read = flash_read;
         prev_wait = flash_waitrequest;
         prev_addr = flash_address;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a read or a sample.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (flash_read) begin
               rd_cycles++;
               check("read_expected", 32'(exp_addr_q.size() > 0), 1);
               if (exp_addr_q.size() > 0) begin
                  check("flash_address", flash_address, exp_addr_q[0]);
                  if (!flash_waitrequest) begin
                     void'(exp_addr_q.pop_front());
                     rd_acc++;
                  end
               end
            end
            if (sample_valid) begin
               check("sample_expected", 32'(exp_samp_q.size() > 0), 1);
               if (exp_samp_q.size() > 0) begin
                  logic [SW:0] e;
                  e = exp_samp_q.pop_front();
                  check("sample", sample, e[SW-1:0]);
                  check("change_with_sample", change, e[SW]);
               end
               samp_seen++;
            end else begin
               check("change_without_sample", change, 0);
            end
            if (change) begin
               chg_cnt++;
               if (ctrl_mode) address = forward ? address + 1'b1 : address - 1'b1;
            end
         end
      end
   end

   task automatic issue_tick();
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
   endtask

   task automatic wait_samples(input int target, input string name);
      int n = 0;
      while (samp_seen < target && n < 200) begin
         @(posedge clk);
         n++;
      end
      check(name, 32'(samp_seen >= target), 1);
   endtask

   task automatic do_word(input logic [AW-1:0] a, input logic dir, input int ws, input int lat,
                          input int gap, input bit flip_dir, input bit over_tick);
      logic [AW-1:0] ea;
      logic [DW-1:0] w;
      int base, rc0, ra0, cc0;
      ws_cfg  = ws;
      lat_cfg = lat;
      if (!ctrl_mode) address = a;
      forward = dir;
      ea = address;
      w  = mem[ea[3:0]];
      exp_addr_q.push_back(ea);
      exp_samp_q.push_back({1'b0, ref_half(w, dir, 0)});
      base = samp_seen; rc0 = rd_cycles; ra0 = rd_acc; cc0 = chg_cnt;
      issue_tick();
      if (over_tick) begin
         @(negedge clk);
         issue_tick();
         exp_overrun = 1;
      end
      if (flip_dir) forward = ~dir;
      wait_samples(base + 1, "first_sample_timeout");
      repeat (gap) @(negedge clk);
      exp_samp_q.push_back({1'b1, ref_half(w, dir, 1)});
      issue_tick();
      wait_samples(base + 2, "second_sample_timeout");
      repeat (2) @(negedge clk);
      check("change_per_word", chg_cnt - cc0, 1);
      check("overrun", overrun, exp_overrun);
      last_rd_cycles = rd_cycles - rc0;
      last_rd_acc    = rd_acc - ra0;
   endtask

   task automatic reset_mid_fetch();
      int a0, r0, s0, n;
      address = 7; forward = 1'b1; lat_cfg = 4; ws_cfg = 0;
      exp_addr_q.push_back(7);
      a0 = rd_acc; r0 = rdv_cnt; s0 = samp_seen; n = 0;
      issue_tick();
      while (rd_acc <= a0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("reset_fetch_accepted", 32'(rd_acc > a0), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_overrun = 0;
      check("rst_flash_read", flash_read, 0);
      check("rst_flash_address", flash_address, 0);
      check("rst_sample", sample, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_change", change, 0);
      check("rst_overrun", overrun, 0);
      repeat (8) @(negedge clk);
      check("stale_response_seen", rdv_cnt - r0, 1);
      check("stale_no_sample", samp_seen - s0, 0);
      check("state_idle_after_stale", dut.state, IDLE);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; sample_tick = 1'b0; forward = 1'b1; address = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      mem[5] = 32'hBEEF_1234;
      mem[7] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      check("reset_flash_read", flash_read, 0);
      check("reset_flash_address", flash_address, 0);
      check("reset_sample", sample, 0);
      check("reset_sample_valid", sample_valid, 0);
      check("reset_change", change, 0);
      check("reset_overrun", overrun, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Forward, backward, wait-state and overrun cases on word 5.
      do_word(5, 1'b1, 0, 3, 0, 0, 0);
      check("fwd_read_cycles", last_rd_cycles, 1);
      do_word(5, 1'b0, 0, 3, 0, 0, 0);
      check("bwd_reads_accepted", last_rd_acc, 1);
      do_word(5, 1'b1, 4, 3, 0, 0, 0);
      check("ws_read_cycles", last_rd_cycles, 5);
      check("ws_reads_accepted", last_rd_acc, 1);
      do_word(5, 1'b1, 0, 5, 0, 0, 1);
      check("overrun_reads_accepted", last_rd_acc, 1);
      repeat (5) @(negedge clk);
      check("overrun_sticky", overrun, 1);

      reset_mid_fetch();

      // Streaming against the address controller model.
      ctrl_mode = 1; address = '0; forward = 1'b1;
      begin
         int c0;
         c0 = chg_cnt;
         for (int i = 0; i < 3; i++) begin
            check("stream_addr", address, i);
            do_word('0, 1'b1, 0, 3, 3, 0, 0);
         end
         check("stream_changes", chg_cnt - c0, 3);
         check("stream_final_addr", address, 3);
         check("stream_overrun", overrun, 0);
      end
      ctrl_mode = 0;

      // Random words: random direction, latency, wait states, gaps and mid-word direction flips.
      for (int i = 0; i < 12; i++) begin
         do_word(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 5)),
                 int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
         check("rand_reads_accepted", last_rd_acc, 1);
      end

      repeat (5) @(negedge clk);
      check("addr_queue_drained", exp_addr_q.size(), 0);
      check("sample_queue_drained", exp_samp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
